image_mem_arbiter: RTL

Two-requester arbiter that shares the single read port of the image frame memory between the display scan-out path (requester 0) and the filter engine (requester 1). It grants one read per cycle, drives the memory address, and tracks the memory's one-cycle read latency. It returns each 24-bit pixel to its owner with a per-requester valid and an out-of-bounds flag. It sits between the pixel consumers and the block-RAM image store.

---
 rtl/img_pkg.sv | 21 ++
 rtl/img_rsp_pipe.sv | 62 ++++++
 rtl/image_mem_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/img_pkg.sv
// Shared types and defaults for the image memory arbiter and its response pipeline.
package img_pkg;

  localparam int IMG_WIDTH  = 320;
  localparam int IMG_HEIGHT = 240;

  typedef logic [23:0] pix_t;
  typedef logic [16:0] addr_t;

  typedef enum logic [1:0] {
    IDLE,
    OWN_0,
    OWN_1
  } arb_state_e;

  // Unsigned 17-bit bound check against the frame size.
  function automatic logic addr_oob(input addr_t addr, input addr_t pix_count);
    return addr >= pix_count;
  endfunction

endpackage

// File: rtl/img_rsp_pipe.sv
// Two-stage response pipeline: tags a granted read, then pairs it with memory data
// one cycle later. Out-of-bounds reads return zero instead of memory data.
module img_rsp_pipe
  import img_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic gnt_v,
  input  logic gnt_id,
  input  logic gnt_oob,
  input  pix_t mem_data,
  output logic rsp_valid_0,
  output logic rsp_valid_1,
  output pix_t rsp_data,
  output logic rsp_oob
);

  logic tag_v_q, tag_v_d;
  logic tag_id_q, tag_id_d;
  logic tag_oob_q, tag_oob_d;
  logic rsp_valid_0_q, rsp_valid_0_d;
  logic rsp_valid_1_q, rsp_valid_1_d;
  pix_t rsp_data_q, rsp_data_d;
  logic rsp_oob_q, rsp_oob_d;

  always_comb begin
    tag_v_d       = gnt_v;
    tag_id_d      = gnt_id;
    tag_oob_d     = gnt_v & gnt_oob;
    rsp_valid_0_d = tag_v_q & ~tag_id_q;
    rsp_valid_1_d = tag_v_q & tag_id_q;
    rsp_oob_d     = tag_oob_q;
    // mem_data only ever reaches a register, never an output directly.
    rsp_data_d    = tag_oob_q ? '0 : mem_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_v_q       <= 1'b0;
      tag_id_q      <= 1'b0;
      tag_oob_q     <= 1'b0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      rsp_data_q    <= '0;
      rsp_oob_q     <= 1'b0;
    end else begin
      tag_v_q       <= tag_v_d;
      tag_id_q      <= tag_id_d;
      tag_oob_q     <= tag_oob_d;
      rsp_valid_0_q <= rsp_valid_0_d;
      rsp_valid_1_q <= rsp_valid_1_d;
      rsp_data_q    <= rsp_data_d;
      rsp_oob_q     <= rsp_oob_d;
    end
  end

  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_oob     = rsp_oob_q;

endmodule

// File: rtl/image_mem_arbiter.sv
// Two-requester burst-limited arbiter for the image memory read port.
// Optional IMG_ARB_STATS_EN adds grant and conflict counters.
module image_mem_arbiter
  import img_pkg::*;
#(
  parameter int WIDTH     = IMG_WIDTH,
  parameter int HEIGHT    = IMG_HEIGHT,
  parameter int BURST_LEN = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_0,
  input  logic        req_1,
  input  logic [16:0] addr_0,
  input  logic [16:0] addr_1,
  output logic        gnt_0,
  output logic        gnt_1,
  output logic [16:0] mem_addr,
  input  logic [23:0] mem_data,
  output logic        rsp_valid_0,
  output logic        rsp_valid_1,
  output logic [23:0] rsp_data,
  output logic        rsp_oob
`ifdef IMG_ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt_0,
  output logic [31:0] stat_gnt_1,
  output logic [31:0] stat_conflict
`endif
);

  localparam addr_t      PIX_COUNT = addr_t'(WIDTH * HEIGHT);
  localparam logic [7:0] BURST_MAX = 8'(BURST_LEN);

  arb_state_e state_q, state_d;
  logic [7:0] beats_q, beats_d;
  logic       own_is_1;
  logic       own_req;
  logic       oth_req;

  always_comb begin
    state_d  = state_q;
    beats_d  = beats_q;
    gnt_0    = 1'b0;
    gnt_1    = 1'b0;
    own_is_1 = (state_q == OWN_1);
    own_req  = own_is_1 ? req_1 : req_0;
    oth_req  = own_is_1 ? req_0 : req_1;
    case (state_q)
      IDLE: begin
        if (req_0) begin
          gnt_0   = 1'b1;
          state_d = OWN_0;
          beats_d = 8'd1;
        end else if (req_1) begin
          gnt_1   = 1'b1;
          state_d = OWN_1;
          beats_d = 8'd1;
        end else begin
          beats_d = 8'd0;
        end
      end
      OWN_0, OWN_1: begin
        // Owner keeps streaming until its burst is spent, unless nobody else wants the port.
        if (own_req && (beats_q < BURST_MAX || !oth_req)) begin
          gnt_0   = ~own_is_1;
          gnt_1   = own_is_1;
          beats_d = (beats_q < BURST_MAX) ? beats_q + 8'd1 : beats_q;
        end else if (oth_req) begin
          gnt_0   = own_is_1;
          gnt_1   = ~own_is_1;
          state_d = own_is_1 ? OWN_0 : OWN_1;
          beats_d = 8'd1;
        end else begin
          state_d = IDLE;
          beats_d = 8'd0;
        end
      end
      default: begin
        state_d = IDLE;
        beats_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beats_q <= 8'd0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
    end
  end

  always_comb begin
    mem_addr = '0;
    if (gnt_0) mem_addr = addr_0;
    else if (gnt_1) mem_addr = addr_1;
  end

  img_rsp_pipe u_rsp_pipe (
    .clk         (clk),
    .rst_n       (rst_n),
    .gnt_v       (gnt_0 | gnt_1),
    .gnt_id      (gnt_1),
    .gnt_oob     (addr_oob(mem_addr, PIX_COUNT)),
    .mem_data    (mem_data),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_data    (rsp_data),
    .rsp_oob     (rsp_oob)
  );

`ifdef IMG_ARB_STATS_EN
  logic [31:0] stat_gnt_0_q, stat_gnt_0_d;
  logic [31:0] stat_gnt_1_q, stat_gnt_1_d;
  logic [31:0] stat_conflict_q, stat_conflict_d;

  always_comb begin
    stat_gnt_0_d    = stat_gnt_0_q + {31'd0, gnt_0};
    stat_gnt_1_d    = stat_gnt_1_q + {31'd0, gnt_1};
    stat_conflict_d = stat_conflict_q + {31'd0, req_0 & req_1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_gnt_0_q    <= '0;
      stat_gnt_1_q    <= '0;
      stat_conflict_q <= '0;
    end else begin
      stat_gnt_0_q    <= stat_gnt_0_d;
      stat_gnt_1_q    <= stat_gnt_1_d;
      stat_conflict_q <= stat_conflict_d;
    end
  end

  assign stat_gnt_0    = stat_gnt_0_q;
  assign stat_gnt_1    = stat_gnt_1_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
